// File: rtl/float_normalize_round.sv
// Normalize, round and pack an unnormalized magnitude into an IEEE-754 binary16 word.
// Two-stage valid/ready pipeline:
//   stage 1 registers the operands, the leading-one index and the working exponent e1;
//   stage 2 shifts, rounds and packs the result into the output registers.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   in_valid/in_ready           input handshake (in_ready is combinational)
//   in_sign, in_exp, in_mant    sign, signed biased exponent (bias 15), magnitude with
//                               the binary point between bits 10 and 9
//   out_valid/out_ready         output handshake
//   out_data                    packed {sign, exp[4:0], frac[9:0]}
//   out_overflow                result saturated to infinity
//   out_underflow               nonzero result flushed to zero
//   out_inexact                 nonzero bits were discarded
module float_normalize_round #(
    parameter int unsigned IN_EXP_W = 8,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [IN_EXP_W-1:0] in_exp,
    input  logic [15:0]         in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_data,
    output logic                out_overflow,
    output logic                out_underflow,
    output logic                out_inexact
);

    // One extra bit so e1 = in_exp + pos - 10 (and the rounding carry) cannot wrap
    localparam int unsigned EW = IN_EXP_W + 1;
    localparam logic [EW-1:0] E_INF = EW'(31);

    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q, s1_sign_d;
    logic                s1_zero_q, s1_zero_d;
    logic [15:0]         s1_mant_q, s1_mant_d;
    logic [3:0]          s1_pos_q, s1_pos_d;
    logic [EW-1:0]       s1_e1_q, s1_e1_d;

    logic                s2_valid_q, s2_valid_d;
    logic [15:0]         data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                inx_q, inx_d;

    logic                s1_adv, s2_adv;
    logic [3:0]          in_pos;

    logic [2:0]          rsh;
    logic [3:0]          lsh;
    logic [20:0]         rext;
    logic [10:0]         sig;
    logic                guard, sticky, round_up;
    logic [11:0]         sum;
    logic [EW-1:0]       e2;
    logic [15:0]         res_data;
    logic                res_ovf, res_udf, res_inx;

    // Index of the most significant set bit (0 for a zero input)
    function automatic logic [3:0] lead_one(input logic [15:0] m);
        logic [3:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) p = 4'(i);
        end
        return p;
    endfunction

    // Handshake: each stage advances when its downstream slot is free or draining
    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign in_pos    = lead_one(in_mant);

    assign out_valid     = s2_valid_q;
    assign out_data      = data_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = udf_q;
    assign out_inexact   = inx_q;

    // Stage 1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_mant_d  = s1_mant_q;
        s1_pos_d   = s1_pos_q;
        s1_e1_d    = s1_e1_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = (in_mant == 16'h0000);
                s1_mant_d = in_mant;
                s1_pos_d  = in_pos;
                s1_e1_d   = {in_exp[IN_EXP_W-1], in_exp} + EW'(in_pos) - EW'(10);
            end
        end
    end

    // Stage 2 datapath: align leading one to bit 10, round, pack
    always_comb begin
        rsh  = 3'(s1_pos_q - 4'd10);
        lsh  = 4'd10 - s1_pos_q;
        rext = {s1_mant_q, 5'b00000} >> rsh;
        if (s1_pos_q > 4'd10) begin
            sig    = 11'(rext >> 5);
            guard  = rext[4];
            sticky = |rext[3:0];
        end else begin
            sig    = 11'(s1_mant_q << lsh);
            guard  = 1'b0;
            sticky = 1'b0;
        end
        round_up = ROUND_EN && guard && (sticky || sig[0]);
        sum      = {1'b0, sig} + 12'(round_up);
        // A carry into bit 11 means the significand became 2.0: frac is then zero
        e2       = s1_e1_q + EW'(sum[11]);

        res_data = {s1_sign_q, 15'h0000};
        res_ovf  = 1'b0;
        res_udf  = 1'b0;
        res_inx  = 1'b0;
        if (s1_zero_q) begin
            res_data = {s1_sign_q, 15'h0000};
        end else if ($signed(e2) >= $signed(E_INF)) begin
            res_data = {s1_sign_q, 5'h1F, 10'h000};
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
        end else if (e2[EW-1] || (e2 == '0)) begin
            res_data = {s1_sign_q, 15'h0000};
            res_udf  = 1'b1;
            res_inx  = 1'b1;
        end else begin
            res_data = {s1_sign_q, 5'(e2), (sum[11] ? 10'h000 : 10'(sum))};
            res_inx  = guard || sticky;
        end
    end

    // Stage 2 next state: output registers hold while stalled
    always_comb begin
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        inx_d      = inx_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d = res_data;
                ovf_d  = res_ovf;
                udf_d  = res_udf;
                inx_d  = res_inx;
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mant_q  <= '0;
            s1_pos_q   <= '0;
            s1_e1_q    <= '0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_mant_q  <= s1_mant_d;
            s1_pos_q   <= s1_pos_d;
            s1_e1_q    <= s1_e1_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            inx_q      <= inx_d;
        end
    end

endmodule

// File: tb/tb_float_normalize_round.sv
// Bench for float_normalize_round: directed cases plus random traffic, with a
// rounding instance and a truncating instance driven by the same stimulus.
module tb_float_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sign, out_ready;
    logic [7:0]  in_exp;
    logic [15:0] in_mant;

    logic        in_ready_r, out_valid_r, ovf_r, udf_r, inx_r;
    logic [15:0] out_data_r;
    logic        in_ready_t, out_valid_t, ovf_t, udf_t, inx_t;
    logic [15:0] out_data_t;

    always #5 clk = ~clk;

    float_normalize_round #(.IN_EXP_W(8), .ROUND_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_overflow(ovf_r), .out_underflow(udf_r), .out_inexact(inx_r)
    );

    float_normalize_round #(.IN_EXP_W(8), .ROUND_EN(1'b0)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
        .out_overflow(ovf_t), .out_underflow(udf_t), .out_inexact(inx_t)
    );

    typedef struct {
        logic [15:0] dr;
        logic [15:0] dt;
        logic [2:0]  fr;
        logic [2:0]  ft;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        q[$];
    exp_t        nxt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] prev_d;
    logic [2:0]  prev_f;
    bit          have_prev = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: value = mant/2^10 * 2^(exp-15), rounded to 11 significant bits
    function automatic void model(input bit s, input int e, input int m, input bit rnd,
                                  output logic [15:0] d, output logic [2:0] f);
        int  p, sh, sg, rem, half, ee;
        bit  inx;
        if (m == 0) begin
            d = {s, 15'h0000};
            f = 3'b000;
            return;
        end
        p = 15;
        while (((m >> p) & 1) == 0) p--;
        ee  = e + p - 10;
        inx = 0;
        if (p > 10) begin
            sh   = p - 10;
            sg   = m >> sh;
            rem  = m & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            inx  = (rem != 0);
            if (rnd && (rem > half || (rem == half && (sg % 2) == 1))) sg++;
            if (sg == 2048) begin
                sg = 1024;
                ee++;
            end
        end else begin
            sg = m << (10 - p);
        end
        if (ee >= 31) begin
            d = {s, 5'h1F, 10'h000};
            f = 3'b101;
        end else if (ee <= 0) begin
            d = {s, 15'h0000};
            f = 3'b011;
        end else begin
            d = {s, 5'(ee), 10'(sg)};
            f = {2'b00, inx};
        end
    endfunction

    task automatic set_model_nxt();
        model(in_sign, int'($signed(in_exp)), int'(in_mant), 1'b1, nxt.dr, nxt.fr);
        model(in_sign, int'($signed(in_exp)), int'(in_mant), 1'b0, nxt.dt, nxt.ft);
        nxt.chk_lat = 0;
        nxt.cyc = 0;
    endtask

    // One clock: sample between edges, score outputs, record an accepted beat
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready_r;
        if (out_valid_r && !out_ready && have_prev) begin
            check("stall_data", 32'(out_data_r), 32'(prev_d));
            check("stall_flags", 32'({ovf_r, udf_r, inx_r}), 32'(prev_f));
        end
        if (out_valid_r && out_ready) begin
            check("unexpected_output", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("data_rne", 32'(out_data_r), 32'(e.dr));
                check("flags_rne", 32'({ovf_r, udf_r, inx_r}), 32'(e.fr));
                check("valid_trunc", 32'(out_valid_t), 32'd1);
                check("data_trunc", 32'(out_data_t), 32'(e.dt));
                check("flags_trunc", 32'({ovf_t, udf_t, inx_t}), 32'(e.ft));
                if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        if (acc) begin
            e = nxt;
            e.cyc = cyc;
            q.push_back(e);
        end
        have_prev = out_valid_r && !out_ready;
        prev_d = out_data_r;
        prev_f = {ovf_r, udf_r, inx_r};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_dir(input bit s, input logic [7:0] e, input logic [15:0] m,
                            input logic [15:0] dr, input logic [2:0] fr,
                            input logic [15:0] dt, input logic [2:0] ft);
        bit acc;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        nxt = '{dr, dt, fr, ft, 0, 1'b1};
        tick(acc);
        check("dir_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        tick(acc);
        tick(acc);
    endtask

    task automatic rand_operands();
        int p;
        in_sign = 1'($urandom);
        if ($urandom % 8 == 0) begin
            in_mant = 16'h0000;
        end else begin
            p = int'($urandom % 16);
            in_mant = 16'((1 << p) | ($urandom & ((1 << p) - 1)));
        end
        if ($urandom % 3 == 0) in_exp = 8'($urandom);
        else in_exp = 8'($urandom_range(0, 40));
    endtask

    initial begin
        bit acc;
        bit pending;
        int sent;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = '0;
        in_mant = '0;
        out_ready = 1'b1;
        nxt = '{16'h0, 16'h0, 3'b0, 3'b0, 0, 1'b0};
        #1;
        check("rst_out_valid", 32'(out_valid_r), 32'd0);
        check("rst_out_data", 32'(out_data_r), 32'd0);
        check("rst_flags", 32'({ovf_r, udf_r, inx_r}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready_r), 32'd1);

        // Directed: latency, normalization, rounding, range limits
        send_dir(1'b0, 8'd15,  16'h0400, 16'h3C00, 3'b000, 16'h3C00, 3'b000);
        send_dir(1'b0, 8'd15,  16'h0800, 16'h4000, 3'b000, 16'h4000, 3'b000);
        send_dir(1'b0, 8'd25,  16'h0001, 16'h3C00, 3'b000, 16'h3C00, 3'b000);
        send_dir(1'b0, 8'd15,  16'h0FFF, 16'h4400, 3'b001, 16'h43FF, 3'b001);
        send_dir(1'b0, 8'd15,  16'h0801, 16'h4000, 3'b001, 16'h4000, 3'b001);
        send_dir(1'b0, 8'd15,  16'h0803, 16'h4002, 3'b001, 16'h4001, 3'b001);
        send_dir(1'b0, 8'd31,  16'h0400, 16'h7C00, 3'b101, 16'h7C00, 3'b101);
        send_dir(1'b0, 8'd29,  16'h0FFF, 16'h7C00, 3'b101, 16'h7BFF, 3'b001);
        send_dir(1'b1, 8'd0,   16'h0400, 16'h8000, 3'b011, 16'h8000, 3'b011);
        send_dir(1'b1, 8'd5,   16'h0000, 16'h8000, 3'b000, 16'h8000, 3'b000);
        send_dir(1'b0, 8'h80,  16'h8000, 16'h0000, 3'b011, 16'h0000, 3'b011);
        send_dir(1'b1, 8'h7F,  16'h8000, 16'hFC00, 3'b101, 16'hFC00, 3'b101);

        // Back-to-back stream at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            rand_operands();
            set_model_nxt();
            nxt.chk_lat = 1'b1;
            tick(acc);
            check("stream_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        repeat (3) tick(acc);

        // Backpressure: fill both stages, stall 3 cycles, then drain in order
        out_ready = 1'b0;
        sent = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_operands();
            set_model_nxt();
            tick(acc);
            if (acc) sent++;
        end
        in_valid = 1'b1;
        rand_operands();
        set_model_nxt();
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 32'(in_ready_r), 32'd0);
            check("bp_out_valid", 32'(out_valid_r), 32'd1);
            tick(acc);
            if (acc) sent++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sent < 4; i++) begin
            tick(acc);
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    rand_operands();
                    set_model_nxt();
                end
            end
        end
        check("bp_all_sent", 32'(sent), 32'd4);
        in_valid = 1'b0;
        repeat (3) tick(acc);
        check("bp_drained", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure
        pending = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                in_valid = ($urandom % 4 != 0);
                rand_operands();
                set_model_nxt();
            end
            out_ready = ($urandom % 4 != 0);
            tick(acc);
            pending = in_valid && !acc;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick(acc);
        check("rand_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_operands();
            set_model_nxt();
            tick(acc);
        end
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready_r), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid_r), 32'd0);
        check("mid_rst_out_valid_t", 32'(out_valid_t), 32'd0);
        check("mid_rst_out_data", 32'(out_data_r), 32'd0);
        check("mid_rst_flags", 32'({ovf_r, udf_r, inx_r}), 32'd0);
        q.delete();
        have_prev = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_dir(1'b0, 8'd15, 16'h0800, 16'h4000, 3'b000, 16'h4000, 3'b000);
        repeat (2) tick(acc);
        check("final_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
